// File: rtl/program_loader_pkg.sv
// Shared definitions for the MiniAlu program loader and the core's instruction field split.
// Holds the frame header default, FSM state encoding and instruction word layout.
package program_loader_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int INSN_WIDTH   = 28;
  localparam int OPCODE_WIDTH = 4;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_COUNT   = 3'd1;
  localparam state_t ST_PAYLOAD = 3'd2;
  localparam state_t ST_CHECK   = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [7:0]              dest;
    logic [7:0]              src1;
    logic [7:0]              src0;
  } insn_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in, instruction-memory write port and core control out.
// master = stream source / memory side, slave = the loader.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 16
) ();

  logic [7:0]                                iByte;
  logic                                      iByteValid;
  logic                                      oByteReady;
  logic                                      oWriteEnable;
  logic [ADDR_WIDTH-1:0]                     oWriteAddress;
  logic [program_loader_pkg::INSN_WIDTH-1:0] oInstruction;
  logic                                      oCpuHold;
  logic                                      oDone;
  logic                                      oError;

  modport master (
    output iByte, iByteValid,
    input  oByteReady, oWriteEnable, oWriteAddress, oInstruction, oCpuHold, oDone, oError
  );

  modport slave (
    input  iByte, iByteValid,
    output oByteReady, oWriteEnable, oWriteAddress, oInstruction, oCpuHold, oDone, oError
  );

endinterface

// File: rtl/program_loader_assembler.sv
// Packs four payload bytes (MS first) into one instruction word and flags a bad opcode byte.
// Completed word is held in the shift register from the edge after the 4th byte; no backpressure.
module instruction_word_assembler
  import program_loader_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       clear,
  input  logic       shiftEn,
  input  logic [7:0] byteIn,
  output logic       wordReady,
  output logic       nibbleError,
  output insn_t      word
);

  logic [1:0]            byteIndex;
  logic [INSN_WIDTH-1:0] shiftReg;

  assign wordReady   = shiftEn && (byteIndex == 2'd3);
  assign nibbleError = shiftEn && (byteIndex == 2'd0) && (byteIn[7:4] != 4'd0);
  assign word        = shiftReg;

  // Byte 0 restarts the register so stale upper bits never leak into the opcode field.
  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      byteIndex <= 2'd0;
      shiftReg  <= '0;
    end else if (shiftEn && !nibbleError) begin
      byteIndex <= byteIndex + 2'd1;
      shiftReg  <= (byteIndex == 2'd0) ? {20'd0, byteIn} : {shiftReg[19:0], byteIn};
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a framed byte stream into instruction memory and holds the core in reset until a good checksum.
// Write strobe one cycle after a word's 4th byte; ready depends on state only, never stalls before DONE.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 16,
  parameter logic [7:0] HEADER     = HEADER_DEFAULT
) (
  input logic             Clock,
  input logic             Reset,
  program_loader_if.slave bus
);

  state_t                state, stateNext;
  logic [7:0]            wordCount;
  logic [7:0]            xorAcc;
  logic [ADDR_WIDTH-1:0] wordAddr;
  logic [ADDR_WIDTH-1:0] writeAddress;
  logic                  writeEnable, error;
  logic                  byteReady, done, cpuHold;
  logic                  transfer, headerSeen, shiftEn, lastWord;
  logic                  wordReady, nibbleError;
  insn_t                 word;

  assign transfer   = bus.iByteValid && byteReady;
  assign headerSeen = transfer && (state == ST_IDLE) && (bus.iByte == HEADER);
  assign shiftEn    = transfer && (state == ST_PAYLOAD);
  assign lastWord   = (wordAddr == ADDR_WIDTH'(wordCount) - ADDR_WIDTH'(1));

  instruction_word_assembler uAssembler (
    .Clock       (Clock),
    .Reset       (Reset),
    .clear       (headerSeen),
    .shiftEn     (shiftEn),
    .byteIn      (bus.iByte),
    .wordReady   (wordReady),
    .nibbleError (nibbleError),
    .word        (word)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:    if (headerSeen) stateNext = ST_COUNT;
      ST_COUNT:   if (transfer) stateNext = (bus.iByte == 8'd0) ? ST_IDLE : ST_PAYLOAD;
      ST_PAYLOAD: begin
        if (nibbleError)                stateNext = ST_IDLE;
        else if (wordReady && lastWord) stateNext = ST_CHECK;
      end
      ST_CHECK:   if (transfer) stateNext = (bus.iByte == xorAcc) ? ST_DONE : ST_IDLE;
      ST_DONE:    stateNext = ST_DONE;
      default:    stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    byteReady = 1'b0;
    done      = 1'b0;
    cpuHold   = 1'b1;
    case (state)
      ST_IDLE, ST_COUNT, ST_PAYLOAD, ST_CHECK: byteReady = 1'b1;
      ST_DONE: begin
        done    = 1'b1;
        cpuHold = 1'b0;
      end
      default: ;
    endcase
  end

  // Words already written on a failed frame stay in memory; only oError reports the rejection.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wordCount    <= 8'd0;
      xorAcc       <= 8'd0;
      wordAddr     <= '0;
      writeAddress <= '0;
      writeEnable  <= 1'b0;
      error        <= 1'b0;
    end else begin
      writeEnable <= 1'b0;
      if (headerSeen) begin
        error    <= 1'b0;
        wordAddr <= '0;
        xorAcc   <= 8'd0;
      end
      if (transfer && (state == ST_COUNT)) begin
        if (bus.iByte == 8'd0) error     <= 1'b1;
        else                   wordCount <= bus.iByte;
      end
      if (shiftEn) begin
        xorAcc <= xorAcc ^ bus.iByte;
        if (nibbleError) error <= 1'b1;
        if (wordReady) begin
          writeEnable  <= 1'b1;
          writeAddress <= wordAddr;
          wordAddr     <= wordAddr + ADDR_WIDTH'(1);
        end
      end
      if (transfer && (state == ST_CHECK) && (bus.iByte != xorAcc)) error <= 1'b1;
    end
  end

  assign bus.oByteReady    = byteReady;
  assign bus.oWriteEnable  = writeEnable;
  assign bus.oWriteAddress = writeAddress;
  assign bus.oInstruction  = word;
  assign bus.oCpuHold      = cpuHold;
  assign bus.oDone         = done;
  assign bus.oError        = error;

endmodule
